// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit directions.
// Holds the FSM state encodings, the default bit period and common widths.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 5;
  localparam int unsigned CNT_W            = 15;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned IDX_W            = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  // Counter value at which the middle of the start bit is checked.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver.
//   i_Rx_Serial   : serial line into the receiver (idle high, 8N1, LSB first)
//   o_Rx_DV       : one-cycle pulse when o_Rx_Byte holds a new good byte
//   o_Rx_Byte     : last good received byte
//   o_Rx_Active   : frame in progress (start confirmed .. stop sampled)
//   o_Framing_Err : one-cycle pulse when the stop bit is sampled low
// master = line driver / byte consumer, slave = the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic              i_Rx_Serial;
  logic              o_Rx_DV;
  logic [DATA_W-1:0] o_Rx_Byte;
  logic              o_Rx_Active;
  logic              o_Framing_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Framing_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Framing_Err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : synchronised output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, oversampled by CLKS_PER_BIT clocks per bit.
//   i_Clock : sole clock, rising edge
//   i_Reset : synchronous active-high reset
//   rx_if   : slave side of uart_rx_if (serial in, byte/valid/active/error out)
// The start bit is confirmed in its middle, each data bit and the stop bit are
// then sampled one full bit period apart. A low stop bit reports a framing
// error and the receiver waits for the line to return high before rearming.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.slave rx_if
);

  localparam int unsigned      HALF   = half_bit(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic              rx_s;

  uart_state_e       state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic [DATA_W-1:0] byte_q,   byte_d;
  logic              dv_q,     dv_d;
  logic              active_q, active_d;
  logic              ferr_q,   ferr_d;

  // Line synchroniser; resets to the idle (high) level.
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (rx_if.i_Rx_Serial),
    .q   (rx_s)
  );

  // Next-state and output logic; pulses default low so they last one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    active_d = active_q;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      // Re-check the line half a bit later to reject glitches.
      START: begin
        if (cnt_q < HALF_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!rx_s) begin
            active_d = 1'b1;
            state_d  = DATA;
          end else begin
            state_d  = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q < LAST_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end

      STOP: begin
        if (cnt_q < LAST_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = CLEANUP;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      // A held-low (break) line must not look like a new start bit.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rx_if.o_Rx_DV       = dv_q;
  assign rx_if.o_Rx_Byte     = byte_q;
  assign rx_if.o_Rx_Active   = active_q;
  assign rx_if.o_Framing_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: serialises random and directed frames, records every
// output pulse with its edge number and compares against expectations derived
// from frame timing arithmetic.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned C    = 5;
  localparam int unsigned HALF = (C - 1) / 2;
  localparam int          LAT  = 3 + HALF + 9 * C;

  logic clk;
  logic rst;
  logic rx;

  uart_rx_if rx_if ();
  assign rx_if.i_Rx_Serial = rx;

  uart_rx #(
    .CLKS_PER_BIT (C)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx_if   (rx_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  logic [7:0] dv_bytes[$];
  int         dv_edges[$];
  int         fe_cnt;
  int         fe_edge;
  int         act_cycles;
  int         overlap;

  // Output monitor: sample 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (rx_if.o_Rx_DV === 1'b1) begin
      dv_bytes.push_back(rx_if.o_Rx_Byte);
      dv_edges.push_back(cyc);
    end
    if (rx_if.o_Framing_Err === 1'b1) begin
      fe_cnt++;
      fe_edge = cyc;
    end
    if (rx_if.o_Rx_Active === 1'b1) act_cycles++;
    if (rx_if.o_Rx_DV === 1'b1 && rx_if.o_Framing_Err === 1'b1) overlap++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    dv_bytes.delete();
    dv_edges.delete();
    fe_cnt     = 0;
    fe_edge    = -1;
    act_cycles = 0;
  endtask

  // Serialise one 8N1 frame, LSB first; t0 is the edge that first sees low.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, output int t0);
    t0 = cyc + 1;
    rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(C);
    end
    rx = stop_b;
    wait_cycles(C);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(4);
    checks++;
    if (rx_if.o_Rx_Byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte got %h want 00", rx_if.o_Rx_Byte);
    end
    checks++;
    if (rx_if.o_Rx_DV !== 1'b0) begin
      errors++;
      $display("FAIL reset_dv got %b want 0", rx_if.o_Rx_DV);
    end
    checks++;
    if (rx_if.o_Rx_Active !== 1'b0) begin
      errors++;
      $display("FAIL reset_active got %b want 0", rx_if.o_Rx_Active);
    end
    checks++;
    if (rx_if.o_Framing_Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr got %b want 0", rx_if.o_Framing_Err);
    end
    rst = 1'b0;
    wait_cycles(3 * C);
  endtask

  task automatic test_single();
    int         t0;
    int         t1;
    logic [7:0] rb;
    rb = 8'($urandom_range(0, 255));
    clear_mon();
    send_frame(8'hA5, 1'b1, t0);
    wait_cycles(2 + $urandom_range(0, 2 * C));
    send_frame(rb, 1'b1, t1);
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != 2) begin
      errors++;
      $display("FAIL single_dv_count got %0d want 2", dv_bytes.size());
    end else begin
      checks++;
      if (dv_bytes[0] !== 8'hA5) begin
        errors++;
        $display("FAIL single_byte0 got %h want a5", dv_bytes[0]);
      end
      checks++;
      if (dv_edges[0] != t0 + LAT) begin
        errors++;
        $display("FAIL single_latency0 got %0d want %0d", dv_edges[0], t0 + LAT);
      end
      checks++;
      if (dv_bytes[1] !== rb) begin
        errors++;
        $display("FAIL single_byte1 got %h want %h", dv_bytes[1], rb);
      end
      checks++;
      if (dv_edges[1] != t1 + LAT) begin
        errors++;
        $display("FAIL single_latency1 got %0d want %0d", dv_edges[1], t1 + LAT);
      end
    end
    checks++;
    if (rx_if.o_Rx_Byte !== rb) begin
      errors++;
      $display("FAIL single_hold got %h want %h", rx_if.o_Rx_Byte, rb);
    end
    checks++;
    if (fe_cnt != 0) begin
      errors++;
      $display("FAIL single_ferr got %0d want 0", fe_cnt);
    end
    checks++;
    if (act_cycles != 2 * 9 * C) begin
      errors++;
      $display("FAIL single_active got %0d want %0d", act_cycles, 2 * 9 * C);
    end
  endtask

  task automatic test_glitch();
    int         t0;
    logic [7:0] rb;
    clear_mon();
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(4 * C);
    checks++;
    if (dv_bytes.size() != 0 || fe_cnt != 0 || act_cycles != 0) begin
      errors++;
      $display("FAIL glitch_quiet got dv=%0d fe=%0d act=%0d want 0 0 0",
               dv_bytes.size(), fe_cnt, act_cycles);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL glitch_idle got %0d want %0d", dut.state_q, IDLE);
    end
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, 1'b1, t0);
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != 1 || dv_bytes[0] !== rb || dv_edges[0] != t0 + LAT) begin
      errors++;
      $display("FAIL glitch_recover got n=%0d want byte %h at %0d", dv_bytes.size(), rb, t0 + LAT);
    end
  endtask

  task automatic test_framing();
    int         t0;
    int         t1;
    int         t2;
    logic [7:0] prev;
    prev = 8'($urandom_range(1, 255));
    send_frame(prev, 1'b1, t0);
    wait_cycles(2 * C);
    clear_mon();
    send_frame(8'h3C, 1'b0, t1);
    rx = 1'b0;
    wait_cycles(C);
    rx = 1'b1;
    wait_cycles(2 * C);
    checks++;
    if (fe_cnt != 1 || fe_edge != t1 + LAT) begin
      errors++;
      $display("FAIL frame_ferr got n=%0d at %0d want 1 at %0d", fe_cnt, fe_edge, t1 + LAT);
    end
    checks++;
    if (dv_bytes.size() != 0) begin
      errors++;
      $display("FAIL frame_no_dv got %0d want 0", dv_bytes.size());
    end
    checks++;
    if (rx_if.o_Rx_Byte !== prev) begin
      errors++;
      $display("FAIL frame_hold got %h want %h", rx_if.o_Rx_Byte, prev);
    end
    send_frame(8'h81, 1'b1, t2);
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != 1 || dv_bytes[0] !== 8'h81 || dv_edges[0] != t2 + LAT) begin
      errors++;
      $display("FAIL frame_next got n=%0d want byte 81 at %0d", dv_bytes.size(), t2 + LAT);
    end
  endtask

  task automatic test_break();
    int         t0;
    int         t1;
    logic [7:0] rb;
    clear_mon();
    t0 = cyc + 1;
    rx = 1'b0;
    wait_cycles(40 * C);
    checks++;
    if (fe_cnt != 1 || fe_edge != t0 + LAT) begin
      errors++;
      $display("FAIL break_ferr got n=%0d at %0d want 1 at %0d", fe_cnt, fe_edge, t0 + LAT);
    end
    checks++;
    if (act_cycles != 9 * C || dv_bytes.size() != 0) begin
      errors++;
      $display("FAIL break_quiet got act=%0d dv=%0d want %0d 0", act_cycles, dv_bytes.size(), 9 * C);
    end
    rx = 1'b1;
    wait_cycles(3 * C);
    checks++;
    if (fe_cnt != 1 || act_cycles != 9 * C) begin
      errors++;
      $display("FAIL break_release got fe=%0d act=%0d want 1 %0d", fe_cnt, act_cycles, 9 * C);
    end
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, 1'b1, t1);
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != 1 || dv_bytes[0] !== rb || dv_edges[0] != t1 + LAT) begin
      errors++;
      $display("FAIL break_recover got n=%0d want byte %h at %0d", dv_bytes.size(), rb, t1 + LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int         t0_q[$];
    int         t0;
    exp_q = '{8'h00, 8'hFF, 8'h55};
    for (int i = 0; i < 3; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    clear_mon();
    foreach (exp_q[i]) begin
      send_frame(exp_q[i], 1'b1, t0);
      t0_q.push_back(t0);
    end
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", dv_bytes.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (dv_bytes[i] !== exp_q[i] || dv_edges[i] != t0_q[i] + LAT) begin
          errors++;
          $display("FAIL b2b_frame%0d got %h at %0d want %h at %0d",
                   i, dv_bytes[i], dv_edges[i], exp_q[i], t0_q[i] + LAT);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int         t0;
    b = 8'h5A;
    clear_mon();
    rx = 1'b0;
    wait_cycles(C);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(C);
    end
    rx = b[4];
    wait_cycles(2);
    rst = 1'b1;
    rx  = 1'b1;
    wait_cycles(3);
    checks++;
    if (rx_if.o_Rx_Byte !== 8'h00 || rx_if.o_Rx_DV !== 1'b0 ||
        rx_if.o_Rx_Active !== 1'b0 || rx_if.o_Framing_Err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got byte=%h dv=%b act=%b fe=%b want 00 0 0 0",
               rx_if.o_Rx_Byte, rx_if.o_Rx_DV, rx_if.o_Rx_Active, rx_if.o_Framing_Err);
    end
    rst = 1'b0;
    wait_cycles(12 * C);
    checks++;
    if (dv_bytes.size() != 0 || fe_cnt != 0) begin
      errors++;
      $display("FAIL midreset_quiet got dv=%0d fe=%0d want 0 0", dv_bytes.size(), fe_cnt);
    end
    send_frame(b, 1'b1, t0);
    wait_cycles(2 * C);
    checks++;
    if (dv_bytes.size() != 1 || dv_bytes[0] !== b || dv_edges[0] != t0 + LAT) begin
      errors++;
      $display("FAIL midreset_recover got n=%0d want byte 5a at %0d", dv_bytes.size(), t0 + LAT);
    end
  endtask

  initial begin
    overlap = 0;
    clear_mon();
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_break();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL dv_ferr_overlap got %0d want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
